// File: rtl/voice_rx_depack.sv
// voice_rx_depack: pairs received UDP payload bytes into little-endian 16-bit
// samples, buffers them in a FIFO and plays them out one sample per request.
// Playback waits in FILL until PREFILL samples are buffered. It falls back to
// FILL whenever a request finds the FIFO empty.
//
// Handshake: there is no backpressure on either side. A byte is taken in
// every cycle rx_byte_vld is high. A sample_req pulse in cycle N always gives
// a sample_vld pulse in cycle N+1. sample_out is 0 when no sample is available.
module voice_rx_depack #(
  parameter int DEPTH_LOG2  = 8,
  parameter int PREFILL     = 128,
  parameter int FRAME_BYTES = 512
) (
  input  logic                  clk_50M,
  input  logic                  sys_rst,
  input  logic                  rx_sof,
  input  logic                  rx_byte_vld,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_eof,
  input  logic                  sample_req,
  output logic [15:0]           sample_out,
  output logic                  sample_vld,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  playing,
  output logic [15:0]           underrun_cnt,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam int                DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] PREFILL_LVL = (DEPTH_LOG2+1)'(PREFILL);
  localparam logic [15:0]       FRAME_LEN   = 16'(FRAME_BYTES);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  // Byte-assembly state
  logic        in_frame;
  logic        byte_phase;   // 1: low byte held, waiting for the high byte
  logic [7:0]  lo_byte;
  logic [15:0] byte_cnt;
  logic        wr_pend;
  logic [15:0] wr_data;

  logic        accept;
  logic        pair_done;
  logic [15:0] cnt_now;
  logic        eof_bad;
  logic        sof_early;

  // FIFO and playback state
  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [0:0]            state;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic underrun;
  logic wr_ok;
  logic wr_drop;

  // Decode the incoming byte: bytes outside a frame are only accepted on rx_sof.
  always_comb begin
    accept    = rx_byte_vld & (rx_sof | in_frame);
    pair_done = accept & ~rx_sof & byte_phase;
    if (rx_sof)
      cnt_now = 16'd1;
    else if (byte_cnt == 16'hFFFF)
      cnt_now = byte_cnt;
    else
      cnt_now = byte_cnt + 16'd1;
    eof_bad   = accept & rx_eof & ((cnt_now != FRAME_LEN) | cnt_now[0]);
    sof_early = rx_byte_vld & rx_sof & in_frame;
  end

  // Byte pairing, frame tracking and the one-cycle frame_err pulse.
  always_ff @(posedge clk_50M or negedge sys_rst) begin
    if (!sys_rst) begin
      in_frame   <= 1'b0;
      byte_phase <= 1'b0;
      lo_byte    <= 8'h00;
      byte_cnt   <= 16'd0;
      wr_pend    <= 1'b0;
      wr_data    <= 16'h0000;
      frame_err  <= 1'b0;
    end else begin
      wr_pend   <= pair_done;
      frame_err <= eof_bad | sof_early;
      if (pair_done)
        wr_data <= {rx_byte, lo_byte};
      if (accept) begin
        if (rx_sof | ~byte_phase)
          lo_byte <= rx_byte;
        if (rx_eof) begin
          // A dangling low byte is dropped by clearing the phase.
          in_frame   <= 1'b0;
          byte_phase <= 1'b0;
          byte_cnt   <= 16'd0;
        end else begin
          in_frame   <= 1'b1;
          byte_phase <= rx_sof ? 1'b1 : ~byte_phase;
          byte_cnt   <= cnt_now;
        end
      end
    end
  end

  // FIFO read/write qualification; a pop frees room for a write in the same cycle.
  always_comb begin
    fifo_empty = (fifo_level == '0);
    fifo_full  = (fifo_level == FULL_LVL);
    pop        = sample_req & (state == ST_PLAY) & ~fifo_empty;
    underrun   = sample_req & (state == ST_PLAY) & fifo_empty;
    wr_ok      = wr_pend & (~fifo_full | pop);
    wr_drop    = wr_pend & fifo_full & ~pop;
  end

  // Sample storage; contents need no reset.
  always_ff @(posedge clk_50M) begin
    if (wr_ok)
      mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_50M or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + {{DEPTH_LOG2{1'b0}}, wr_ok}
                               - {{DEPTH_LOG2{1'b0}}, pop};
    end
  end

  // FILL/PLAY state machine.
  always_ff @(posedge clk_50M or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= ST_FILL;
    end else begin
      case (state)
        ST_FILL: if (fifo_level >= PREFILL_LVL) state <= ST_PLAY;
        ST_PLAY: if (underrun) state <= ST_FILL;
        default: state <= ST_FILL;
      endcase
    end
  end

  assign playing = (state == ST_PLAY);

  // Sample response, sticky overflow and saturating underrun counter.
  always_ff @(posedge clk_50M or negedge sys_rst) begin
    if (!sys_rst) begin
      sample_out   <= 16'h0000;
      sample_vld   <= 1'b0;
      overflow     <= 1'b0;
      underrun_cnt <= 16'd0;
    end else begin
      sample_vld <= sample_req;
      if (sample_req)
        sample_out <= pop ? mem[rd_ptr] : 16'h0000;
      if (wr_drop)
        overflow <= 1'b1;
      if (underrun && underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_voice_rx_depack.sv
// Directed bench for voice_rx_depack: a default-size instance plus a 16-deep
// instance for the overflow and full-FIFO cases.
module tb_voice_rx_depack;

  logic clk_50M = 1'b0;
  logic sys_rst;

  logic        rx_sof, rx_byte_vld, rx_eof, sample_req;
  logic [7:0]  rx_byte;
  logic [15:0] sample_out, underrun_cnt;
  logic        sample_vld, playing, overflow, frame_err;
  logic [8:0]  fifo_level;

  logic        s_sof, s_byte_vld, s_eof, s_req;
  logic [7:0]  s_byte;
  logic [15:0] s_out, s_underrun_cnt;
  logic        s_vld, s_playing, s_overflow, s_frame_err;
  logic [4:0]  s_level;

  int checks = 0;
  int errors = 0;

  // Clock and watchdog
  always #10 clk_50M = ~clk_50M;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout required finish");
    $fatal(1);
  end

  voice_rx_depack dut (
    .clk_50M(clk_50M), .sys_rst(sys_rst), .rx_sof(rx_sof), .rx_byte_vld(rx_byte_vld),
    .rx_byte(rx_byte), .rx_eof(rx_eof), .sample_req(sample_req), .sample_out(sample_out),
    .sample_vld(sample_vld), .fifo_level(fifo_level), .playing(playing),
    .underrun_cnt(underrun_cnt), .overflow(overflow), .frame_err(frame_err)
  );

  voice_rx_depack #(.DEPTH_LOG2(4), .PREFILL(8), .FRAME_BYTES(40)) dut_s (
    .clk_50M(clk_50M), .sys_rst(sys_rst), .rx_sof(s_sof), .rx_byte_vld(s_byte_vld),
    .rx_byte(s_byte), .rx_eof(s_eof), .sample_req(s_req), .sample_out(s_out),
    .sample_vld(s_vld), .fifo_level(s_level), .playing(s_playing),
    .underrun_cnt(s_underrun_cnt), .overflow(s_overflow), .frame_err(s_frame_err)
  );

  // Driver tasks
  task automatic tick;
    @(posedge clk_50M);
    #1;
  endtask

  task automatic apply_reset;
    sys_rst = 1'b0;
    tick;
    tick;
    sys_rst = 1'b1;
    tick;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sof, input logic eof);
    rx_byte = b; rx_sof = sof; rx_eof = eof; rx_byte_vld = 1'b1;
    tick;
    rx_byte_vld = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
  endtask

  task automatic s_send_byte(input logic [7:0] b, input logic sof, input logic eof);
    s_byte = b; s_sof = sof; s_eof = eof; s_byte_vld = 1'b1;
    tick;
    s_byte_vld = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
  endtask

  // Sends n bytes carrying samples first, first+1, ... little-endian.
  // n_req > 0 raises sample_req on n_req even byte slots starting at byte 400.
  task automatic send_frame(input int n, input logic [15:0] first,
                            input bit with_eof, input int n_req);
    logic [15:0] v;
    logic [7:0]  b;
    for (int i = 0; i < n; i++) begin
      v = first + 16'(i / 2);
      b = ((i % 2) == 0) ? v[7:0] : v[15:8];
      sample_req = (n_req > 0) && (i >= 400) && (i < 400 + 2 * n_req) && ((i % 2) == 0);
      send_byte(b, i == 0, with_eof && (i == n - 1));
      sample_req = 1'b0;
    end
  endtask

  task automatic do_req;
    sample_req = 1'b1;
    tick;
    sample_req = 1'b0;
  endtask

  // Scenario tasks
  task automatic test_reset;
    logic [44:0] obs;
    repeat (3) tick;
    obs = {sample_out, sample_vld, fifo_level, playing, underrun_cnt, overflow, frame_err};
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", obs); end
    checks++; if (s_level !== 5'd0 || s_playing !== 1'b0) begin errors++; $display("FAIL reset_small: got level %0d playing %b expected 0 0", s_level, s_playing); end
    sys_rst = 1'b1;
    tick;
    checks++; if (fifo_level !== 9'd0 || playing !== 1'b0) begin errors++; $display("FAIL reset_release: got level %0d playing %b expected 0 0", fifo_level, playing); end
  endtask

  task automatic test_full_frame;
    send_frame(512, 16'h0001, 1'b1, 0);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL full_frame_err: got %b expected 0", frame_err); end
    tick; tick;
    checks++; if (fifo_level !== 9'd256) begin errors++; $display("FAIL full_frame_level: got %0d expected 256", fifo_level); end
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL full_frame_playing: got %b expected 1", playing); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_frame_overflow: got %b expected 0", overflow); end
    for (int i = 0; i < 256; i++) begin
      do_req;
      checks++; if (sample_vld !== 1'b1 || sample_out !== 16'(i + 1)) begin errors++; $display("FAIL play_sample %0d: got vld %b data %h expected 1 %h", i, sample_vld, sample_out, 16'(i + 1)); end
      tick;
      checks++; if (sample_vld !== 1'b0) begin errors++; $display("FAIL play_vld_pulse %0d: got %b expected 0", i, sample_vld); end
    end
    checks++; if (fifo_level !== 9'd0 || playing !== 1'b1) begin errors++; $display("FAIL drained: got level %0d playing %b expected 0 1", fifo_level, playing); end
  endtask

  task automatic test_underrun_refill;
    do_req;
    checks++; if (sample_vld !== 1'b1 || sample_out !== 16'h0000) begin errors++; $display("FAIL underrun_resp: got vld %b data %h expected 1 0000", sample_vld, sample_out); end
    checks++; if (underrun_cnt !== 16'd1 || playing !== 1'b0) begin errors++; $display("FAIL underrun_state: got cnt %0d playing %b expected 1 0", underrun_cnt, playing); end
    send_frame(256, 16'h0200, 1'b1, 0);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_frame_err: got %b expected 1", frame_err); end
    tick;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL short_frame_err_pulse: got %b expected 0", frame_err); end
    checks++; if (fifo_level !== 9'd128 || playing !== 1'b0) begin errors++; $display("FAIL refill_level: got level %0d playing %b expected 128 0", fifo_level, playing); end
    tick;
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL refill_play: got %b expected 1", playing); end
  endtask

  task automatic test_early_sof;
    send_frame(6, 16'h0300, 1'b0, 0);
    send_byte(8'h11, 1'b1, 1'b0);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL early_sof_err: got %b expected 1", frame_err); end
    send_byte(8'h22, 1'b0, 1'b0);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL early_sof_pulse: got %b expected 0", frame_err); end
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL early_sof_eof_err: got %b expected 1", frame_err); end
    tick; tick;
    checks++; if (fifo_level !== 9'd133) begin errors++; $display("FAIL early_sof_level: got %0d expected 133", fifo_level); end
    do_req;
    checks++; if (sample_out !== 16'h0200) begin errors++; $display("FAIL early_sof_head: got %h expected 0200", sample_out); end
  endtask

  task automatic test_reset_mid_frame;
    logic [44:0] obs;
    send_frame(10, 16'h0500, 1'b0, 0);
    #3;
    sys_rst = 1'b0;
    #1;
    obs = {sample_out, sample_vld, fifo_level, playing, underrun_cnt, overflow, frame_err};
    checks++; if (obs !== '0) begin errors++; $display("FAIL midreset_outputs: got %h expected 0", obs); end
    tick; tick;
    checks++; if (fifo_level !== 9'd0 || underrun_cnt !== 16'd0) begin errors++; $display("FAIL midreset_hold: got level %0d cnt %0d expected 0 0", fifo_level, underrun_cnt); end
    sys_rst = 1'b1;
    for (int i = 0; i < 20; i++)
      send_byte(8'hAA, 1'b0, i == 19);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL stray_err: got %b expected 0", frame_err); end
    tick; tick;
    checks++; if (fifo_level !== 9'd0) begin errors++; $display("FAIL stray_level: got %0d expected 0", fifo_level); end
    send_frame(512, 16'h1000, 1'b1, 0);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL post_reset_err: got %b expected 0", frame_err); end
    tick; tick;
    checks++; if (fifo_level !== 9'd256) begin errors++; $display("FAIL post_reset_level: got %0d expected 256", fifo_level); end
    do_req;
    checks++; if (sample_out !== 16'h1000) begin errors++; $display("FAIL post_reset_first: got %h expected 1000", sample_out); end
  endtask

  task automatic test_fill_request;
    apply_reset;
    send_frame(200, 16'h0001, 1'b1, 0);
    tick; tick;
    checks++; if (fifo_level !== 9'd100) begin errors++; $display("FAIL fill_level: got %0d expected 100", fifo_level); end
    do_req;
    checks++; if (sample_vld !== 1'b1 || sample_out !== 16'h0000) begin errors++; $display("FAIL fill_resp: got vld %b data %h expected 1 0000", sample_vld, sample_out); end
    checks++; if (fifo_level !== 9'd100 || playing !== 1'b0 || underrun_cnt !== 16'd0) begin errors++; $display("FAIL fill_state: got level %0d playing %b cnt %0d expected 100 0 0", fifo_level, playing, underrun_cnt); end
  endtask

  task automatic test_odd_frames;
    apply_reset;
    send_frame(511, 16'h0001, 1'b1, 0);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL odd_err: got %b expected 1", frame_err); end
    tick;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL odd_err_pulse: got %b expected 0", frame_err); end
    tick;
    checks++; if (fifo_level !== 9'd255) begin errors++; $display("FAIL odd_level: got %0d expected 255", fifo_level); end
    for (int i = 0; i < 255; i++) begin
      do_req;
      checks++; if (sample_vld !== 1'b1 || sample_out !== 16'(i + 1)) begin errors++; $display("FAIL odd_drain %0d: got vld %b data %h expected 1 %h", i, sample_vld, sample_out, 16'(i + 1)); end
    end
    // Empty FIFO, write and request in the same cycle while playing.
    send_byte(8'h34, 1'b1, 1'b0);
    send_byte(8'h12, 1'b0, 1'b1);
    do_req;
    checks++; if (sample_vld !== 1'b1 || sample_out !== 16'h0000) begin errors++; $display("FAIL empty_wr_resp: got vld %b data %h expected 1 0000", sample_vld, sample_out); end
    checks++; if (underrun_cnt !== 16'd1 || playing !== 1'b0 || fifo_level !== 9'd1) begin errors++; $display("FAIL empty_wr_state: got cnt %0d playing %b level %0d expected 1 0 1", underrun_cnt, playing, fifo_level); end
    apply_reset;
    send_frame(514, 16'h0001, 1'b1, 4);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL long_err: got %b expected 1", frame_err); end
    tick; tick;
    checks++; if (fifo_level !== 9'd253 || overflow !== 1'b0) begin errors++; $display("FAIL long_level: got level %0d ovf %b expected 253 0", fifo_level, overflow); end
    for (int i = 0; i < 253; i++) begin
      do_req;
      checks++; if (sample_out !== 16'(i + 5)) begin errors++; $display("FAIL long_drain %0d: got %h expected %h", i, sample_out, 16'(i + 5)); end
    end
  endtask

  task automatic test_small_overflow;
    logic [15:0] v;
    for (int i = 0; i < 40; i++) begin
      v = 16'(i / 2 + 1);
      s_send_byte(((i % 2) == 0) ? v[7:0] : v[15:8], i == 0, i == 39);
    end
    checks++; if (s_frame_err !== 1'b0) begin errors++; $display("FAIL small_err: got %b expected 0", s_frame_err); end
    tick; tick;
    checks++; if (s_level !== 5'd16 || s_overflow !== 1'b1) begin errors++; $display("FAIL small_full: got level %0d ovf %b expected 16 1", s_level, s_overflow); end
    checks++; if (s_playing !== 1'b1) begin errors++; $display("FAIL small_playing: got %b expected 1", s_playing); end
    s_send_byte(8'h99, 1'b1, 1'b0);
    s_send_byte(8'h00, 1'b0, 1'b0);
    s_req = 1'b1;
    tick;
    s_req = 1'b0;
    checks++; if (s_vld !== 1'b1 || s_out !== 16'h0001) begin errors++; $display("FAIL small_full_rw: got vld %b data %h expected 1 0001", s_vld, s_out); end
    tick;
    checks++; if (s_level !== 5'd16) begin errors++; $display("FAIL small_full_rw_level: got %0d expected 16", s_level); end
  endtask

  // Sequence and final report
  initial begin
    sys_rst = 1'b0;
    rx_sof = 1'b0; rx_byte_vld = 1'b0; rx_byte = 8'h00; rx_eof = 1'b0; sample_req = 1'b0;
    s_sof = 1'b0; s_byte_vld = 1'b0; s_byte = 8'h00; s_eof = 1'b0; s_req = 1'b0;
    test_reset;
    test_full_frame;
    test_underrun_refill;
    test_early_sof;
    test_reset_mid_frame;
    test_fill_request;
    test_odd_frames;
    test_small_overflow;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
